game_round_controller: RTL
==========================

// Module: game_round_controller
// PURPOSE
//  Sequences one arcade basketball round: idle, 3-2-1 ready count, timed play window, leaderboard commit, result hold.
//  Owns the score counter and the seconds countdown, gating hoop hits to the play window only.
//  Emits exactly one leaderboard commit pulse per completed round.
//  Sits between the hoop switch inputs and the leaderboard / seven-segment / VGA display logic.
// PARAMETERS
//  TICK_DIV        50_000_000  clock cycles per game second
//  ROUND_SECS      30          play-window length, seconds (1..255)
//  READY_SECS      3           pre-start countdown, seconds (1..255)
//  DONE_HOLD_SECS  5           result display hold before returning to IDLE (1..255)
//  SCORE_W         8           score counter width
//  BONUS_SCORE     10          score that triggers bonus time (BONUS_TIME_EN only)
//  BONUS_SECS      10          seconds added on bonus (BONUS_TIME_EN only)
// PORTS
//  clock       in   1        system clock
//  reset       in   1        synchronous, active-low
//  start_btn   in   1        start request, level; rising edge is used, already synchronised
//  hoop_hit    in   1        OR of hoop switches, level; rising edge = one basket
//  state       out  3        current FSM state, encoded per game_pkg
//  time_left   out  8        seconds remaining in READY/PLAY/DONE counters (active counter)
//  score       out  SCORE_W  current round score
//  score_en    out  1        high while in PLAY
//  lb_commit   out  1        one-cycle pulse, leaderboard write strobe
//  lb_score    out  SCORE_W  score presented with lb_commit, held until next commit
//  bonus_flag  out  1        bonus awarded this round
// BEHAVIOUR
//  All outputs registered. Reset (reset==0 at clock edge): state=IDLE, time_left=ROUND_SECS, score=0, lb_score=0,
//   score_en=0, lb_commit=0, bonus_flag=0, prescaler=0, edge-detect registers=0. Reset mid-round aborts it; no commit.
//  Edge detect: start_re = start_btn & ~start_q; hit_re = hoop_hit & ~hit_q; one-cycle detection latency.
//  Prescaler: runs in READY, PLAY, DONE; cleared on every state entry; tick pulses when count == TICK_DIV-1, then wraps to 0.
//  IDLE: start_re -> READY, time_left=READY_SECS. Previous score stays displayed.
//  READY: tick decrements time_left; tick with time_left==1 -> PLAY, time_left=ROUND_SECS, score=0, bonus_flag=0.
//  PLAY: score_en=1; hit_re -> score+1, saturating at 2^SCORE_W-1. tick decrements time_left;
//   tick with time_left==1 -> time_left=0, -> COMMIT. A hit in that same cycle is counted.
//  COMMIT (1 cycle): lb_commit=1, lb_score=score (includes any final-cycle hit); -> DONE, time_left=DONE_HOLD_SECS.
//  DONE: hits ignored, score held; tick decrements; tick with time_left==1 -> IDLE, time_left=ROUND_SECS.
//  start_re ignored in READY, PLAY, COMMIT, DONE (no restart, no queueing).
//  hit_re ignored outside PLAY; hoop_hit held high counts once.
// CONFIGURATION
//  Macro GAME_BONUS_TIME_EN:
//   defined: in PLAY, first cycle score becomes BONUS_SCORE, time_left += BONUS_SECS (saturate 255), bonus_flag=1;
//    once per round. Coincident tick: time_left = time_left - 1 + BONUS_SECS. Coincident final tick (time_left==1):
//    bonus wins, stay in PLAY with time_left=BONUS_SECS.
//   undefined: no bonus logic; bonus_flag tied 0; BONUS_* unused.
// STRUCTURE
//  game_pkg: state typedef/encodings (IDLE=0, READY=1, PLAY=2, COMMIT=3, DONE=4), SCORE_W default, time width (8).
//  Sub-module sec_prescaler (TICK_DIV; ports clock, reset, clr, run, tick). FSM, counters, edge detect stay in top.
// TESTING  (bench: TICK_DIV=4, ROUND_SECS=5, READY_SECS=2, DONE_HOLD_SECS=2, BONUS_SCORE=3, BONUS_SECS=2)
//  Full round, 2 hits in PLAY -> READY 8 cycles, PLAY 20 cycles, one lb_commit with lb_score=2, IDLE after DONE 8 cycles.
//  Hit on exact cycle of final PLAY tick -> counted; lb_score=prior+1; exactly one lb_commit.
//  Hits during IDLE/READY/DONE and hoop_hit held high 10 cycles in PLAY -> score increments by 1 only.
//  start_btn pulsed in PLAY and DONE -> no state change; pulse in IDLE -> READY, time_left=2.
//  Reset asserted mid-PLAY with score=4 -> next cycle IDLE, score=0, time_left=5, no lb_commit.
//  GAME_BONUS_TIME_EN: 3rd hit with time_left=2 -> time_left=4, bonus_flag=1; 4th hit no further bonus; 255 saturation.

Source files
------------

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared types and constants for the arcade basketball round controller.
//   - game_state_t : round FSM state encoding (IDLE=0 .. DONE=4), also driven
//                    out on the controller's state port for the display logic.
//   - TIME_W       : width of the seconds countdown (0..255).
//   - SCORE_W_DEFAULT : default score counter width.
//   - sat_add_time : saturating add for the seconds countdown.
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int TIME_W          = 8;
    localparam int SCORE_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READY  = 3'd1,
        PLAY   = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } game_state_t;

    // Add two countdown values, clamping at the largest displayable second.
    function automatic logic [TIME_W-1:0] sat_add_time(
        input logic [TIME_W-1:0] a,
        input logic [TIME_W-1:0] b
    );
        logic [TIME_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[TIME_W] ? {TIME_W{1'b1}} : sum[TIME_W-1:0];
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// -----------------------------------------------------------------------------
// sec_prescaler
//   Divides the system clock down to one-cycle "game second" ticks.
//   Ports:
//     clock  in   system clock
//     reset  in   synchronous, active-low
//     clr    in   restart the second from zero (used on every state entry)
//     run    in   count enable; the counter is held at zero while low
//     tick   out  high for the one cycle in which count == TICK_DIV-1
// -----------------------------------------------------------------------------
module sec_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // tick comes straight off the count compare so the controller can act on it
    // in the same cycle the second elapses.
    assign tick = run && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || !run || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// -----------------------------------------------------------------------------
// game_round_controller
//   Sequences one arcade basketball round:
//     IDLE -> READY (countdown) -> PLAY (timed window) -> COMMIT -> DONE -> IDLE
//   Owns the score counter and the seconds countdown; hoop hits only count in
//   PLAY, and exactly one leaderboard strobe is issued per completed round.
//   All outputs are registered.
//
//   Optional feature (compile-time macro GAME_BONUS_TIME_EN):
//     defined   - the first hit of a round that brings the score to BONUS_SCORE
//                 adds BONUS_SECS to the countdown (saturating) and sets
//                 bonus_flag; a bonus on the final tick keeps the round alive.
//     undefined - no bonus logic, bonus_flag tied low.
//
//   Ports:
//     clock       in   system clock
//     reset       in   synchronous, active-low; aborts a round without commit
//     start_btn   in   start request level (already synchronised)
//     hoop_hit    in   OR of hoop switches, rising edge = one basket
//     state       out  current FSM state (game_state_t)
//     time_left   out  seconds remaining on the active countdown
//     score       out  current round score (saturating)
//     score_en    out  high while in PLAY
//     lb_commit   out  one-cycle leaderboard write strobe
//     lb_score    out  score presented with lb_commit, held until next commit
//     bonus_flag  out  bonus awarded this round
// -----------------------------------------------------------------------------
module game_round_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV       = 50_000_000,
    parameter int ROUND_SECS     = 30,
    parameter int READY_SECS     = 3,
    parameter int DONE_HOLD_SECS = 5,
    parameter int SCORE_W        = SCORE_W_DEFAULT,
    parameter int BONUS_SCORE    = 10,
    parameter int BONUS_SECS     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               hoop_hit,
    output game_state_t        state,
    output logic [TIME_W-1:0]  time_left,
    output logic [SCORE_W-1:0] score,
    output logic               score_en,
    output logic               lb_commit,
    output logic [SCORE_W-1:0] lb_score,
    output logic               bonus_flag
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [TIME_W-1:0]  ONE_SEC   = TIME_W'(1);

    // Edge detection: the registered copy lags the input by one cycle.
    logic start_q, hit_q;
    logic start_re, hit_re;

    assign start_re = start_btn && !start_q;
    assign hit_re   = hoop_hit && !hit_q;

    // Next-state values computed combinationally, then registered.
    game_state_t        state_next;
    logic [TIME_W-1:0]  time_next;
    logic [TIME_W-1:0]  time_base;
    logic [SCORE_W-1:0] score_next;
    logic [SCORE_W-1:0] lb_score_next;
    logic               hit_counted;

    // Second prescaler: runs only in the timed states and restarts on every
    // state change so each countdown starts on a full second.
    logic tick, run, clr;

    assign run = (state == READY) || (state == PLAY) || (state == DONE);
    assign clr = (state_next != state);

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .run   (run),
        .tick  (tick)
    );

`ifdef GAME_BONUS_TIME_EN
    logic bonus_next;
    logic bonus_hit;

    // Bonus fires only on the hit that actually lands the score on BONUS_SCORE,
    // and bonus_flag blocks a second award within the same round.
    assign bonus_hit = hit_counted && !bonus_flag &&
                       ((score + SCORE_W'(1)) == SCORE_W'(BONUS_SCORE));
`else
    // Bonus parameters have no effect in this build.
    logic unused_bonus_cfg;
    assign unused_bonus_cfg = (BONUS_SCORE != 0) ^ (BONUS_SECS != 0);
`endif

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next    = state;
        time_next     = time_left;
        score_next    = score;
        lb_score_next = lb_score;
`ifdef GAME_BONUS_TIME_EN
        bonus_next    = bonus_flag;
`endif
        // Countdown value after this cycle's tick (if any).
        time_base     = tick ? (time_left - ONE_SEC) : time_left;
        hit_counted   = hit_re && (score != SCORE_MAX);

        case (state)
            IDLE: begin
                if (start_re) begin
                    state_next = READY;
                    time_next  = TIME_W'(READY_SECS);
                end
            end

            READY: begin
                time_next = time_base;
                if (tick && (time_left == ONE_SEC)) begin
                    state_next = PLAY;
                    time_next  = TIME_W'(ROUND_SECS);
                    score_next = '0;
`ifdef GAME_BONUS_TIME_EN
                    bonus_next = 1'b0;
`endif
                end
            end

            PLAY: begin
                if (hit_counted) begin
                    score_next = score + SCORE_W'(1);
                end
                time_next = time_base;
                if (tick && (time_left == ONE_SEC)) begin
                    state_next = COMMIT;
                end
`ifdef GAME_BONUS_TIME_EN
                // Bonus overrides a coincident final tick: the round continues.
                if (bonus_hit) begin
                    bonus_next = 1'b1;
                    time_next  = sat_add_time(time_base, TIME_W'(BONUS_SECS));
                    state_next = PLAY;
                end
`endif
            end

            COMMIT: begin
                state_next = DONE;
                time_next  = TIME_W'(DONE_HOLD_SECS);
            end

            DONE: begin
                time_next = time_base;
                if (tick && (time_left == ONE_SEC)) begin
                    state_next = IDLE;
                    time_next  = TIME_W'(ROUND_SECS);
                end
            end

            default: begin
                state_next = IDLE;
                time_next  = TIME_W'(ROUND_SECS);
            end
        endcase

        // Capture uses score_next so a hit on the final tick is included.
        if ((state == PLAY) && (state_next == COMMIT)) begin
            lb_score_next = score_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            time_left <= TIME_W'(ROUND_SECS);
            score     <= '0;
            score_en  <= 1'b0;
            lb_commit <= 1'b0;
            lb_score  <= '0;
            start_q   <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state     <= state_next;
            time_left <= time_next;
            score     <= score_next;
            score_en  <= (state_next == PLAY);
            lb_commit <= (state_next == COMMIT);
            lb_score  <= lb_score_next;
            start_q   <= start_btn;
            hit_q     <= hoop_hit;
        end
    end

`ifdef GAME_BONUS_TIME_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            bonus_flag <= 1'b0;
        end else begin
            bonus_flag <= bonus_next;
        end
    end
`else
    assign bonus_flag = 1'b0;
`endif

endmodule
